ram_port_arbiter: RTL

- Shares one read/write port of the flip-flop RAM (en_/rw_/addr/wdata/rdata, active-low enable) among REQ requesters.
- Uses round-robin arbitration with an optional per-requester lock for back-to-back bursts.
- Each requester has a valid/ready request channel and a fixed-latency read-response channel.
- The block sits between client engines and a single RAM port; one instance is used per shared port.

---
 rtl/ram_port_arbiter.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one flip-flop RAM port among REQ requesters.
// A requester can hold the port with req_lock to issue back-to-back bursts.
// Each accepted read returns one rsp_valid pulse one cycle after acceptance.
module ram_port_arbiter #(
  parameter int REQ    = 4,
  parameter int DATA   = 16,
  parameter int DEPTH  = 16,
  parameter int OUTREG = 0,
  parameter int ADDR   = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [REQ-1:0]      req_valid,
  input  logic [REQ-1:0]      req_rw_,
  input  logic [REQ-1:0]      req_lock,
  input  logic [REQ*ADDR-1:0] req_addr,
  input  logic [REQ*DATA-1:0] req_wdata,
  output logic [REQ-1:0]      req_ready,
  output logic [REQ-1:0]      rsp_valid,
  output logic [DATA-1:0]     rsp_data,
  output logic                ram_en_,
  output logic                ram_rw_,
  output logic [ADDR-1:0]     ram_addr,
  output logic [DATA-1:0]     ram_wdata,
  input  logic [DATA-1:0]     ram_rdata
);

  localparam int PW = $clog2(REQ);
  localparam logic [PW-1:0] LAST = PW'(REQ - 1);

  typedef enum logic {ARB = 1'b0, LOCK = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] rr_ptr_q, rr_ptr_d;
  logic [PW-1:0] owner_q, owner_d;

  logic          gnt_any;
  logic [PW-1:0] gnt_idx;
  logic [PW-1:0] scan;
  logic [REQ-1:0] grant;
  logic          rd_acc_p0;
  logic [REQ-1:0] vld_p1;

  // Grant selection: the lock owner alone while locked, otherwise the first
  // valid requester found scanning upward from rr_ptr with wrap-around.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    scan    = rr_ptr_q;
    if (state_q == LOCK) begin
      gnt_any = req_valid[owner_q];
      gnt_idx = owner_q;
    end else begin
      for (int i = 0; i < REQ; i++) begin
        if (!gnt_any && req_valid[scan]) begin
          gnt_any = 1'b1;
          gnt_idx = scan;
        end
        scan = (scan == LAST) ? '0 : scan + 1'b1;
      end
    end
    // No grant may leak out while the block is held in reset.
    if (!reset) begin
      gnt_any = 1'b0;
    end
    grant = '0;
    if (gnt_any) begin
      grant[gnt_idx] = 1'b1;
    end
  end

  assign req_ready = grant;
  assign rd_acc_p0 = gnt_any & req_rw_[gnt_idx];

  // RAM port mux from the granted requester; idle value when nothing is granted.
  always_comb begin
    ram_en_   = ~gnt_any;
    ram_rw_   = 1'b1;
    ram_addr  = '0;
    ram_wdata = '0;
    for (int i = 0; i < REQ; i++) begin
      if (grant[i]) begin
        ram_rw_   = req_rw_[i];
        ram_addr  = req_addr[i*ADDR +: ADDR];
        ram_wdata = req_wdata[i*DATA +: DATA];
      end
    end
  end

  // Next state: a locked access pins the owner, an unlocked one advances the pointer.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    if (gnt_any) begin
      if (req_lock[gnt_idx]) begin
        state_d = LOCK;
        owner_d = gnt_idx;
      end else begin
        state_d  = ARB;
        rr_ptr_d = (gnt_idx == LAST) ? '0 : gnt_idx + 1'b1;
      end
    end
  end

  // Arbitration state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ARB;
      rr_ptr_q <= '0;
      owner_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
    end
  end

  // ---- stage p0 -> p1: one-hot response tag of an accepted read ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p1 <= '0;
    end else begin
      vld_p1 <= rd_acc_p0 ? grant : '0;
    end
  end

  assign rsp_valid = vld_p1;

  if (OUTREG == 0) begin : g_comb_ram
    logic [DATA-1:0] data_p1;

    // ---- stage p0 -> p1: capture combinational RAM data with the tag ----
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        data_p1 <= '0;
      end else begin
        data_p1 <= rd_acc_p0 ? ram_rdata : '0;
      end
    end

    assign rsp_data = data_p1;
  end else begin : g_reg_ram
    // The RAM already registers its output, aligned with the tag.
    assign rsp_data = (|vld_p1) ? ram_rdata : '0;
  end

endmodule
